gf_vec_add_ctrl: RTL and testbench

Sequencer that streams two GF(2^8) operand vectors through one gf_add datapath and writes the element-wise sum back to memory. On a start pulse it walks addresses 0..N_ELEM-1 on two read ports (operand A, operand B) with a fixed read latency, feeds the returned bytes to gf_add, and issues aligned writes to a result memory. It sits between the SDitH arithmetic top-level FSM and the operand and result BRAMs.

---
 rtl/gf_vec_add_ctrl_pkg.sv | 15 +
 rtl/gf_add.sv | 28 ++
 rtl/gf_vec_add_ctrl.sv | 138 +++++++++++++
 tb/tb_gf_vec_add_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_vec_add_ctrl_pkg.sv
// Shared types and defaults for the vector GF(2^8) controllers.
package gf_vec_add_ctrl_pkg;

  localparam int unsigned GfW       = 8;
  localparam int unsigned DefNElem  = 16;
  localparam int unsigned DefRamLat = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/gf_add.sv
// GF(2^8) addition datapath: the sum is a plain XOR, o_done echoes i_start one cycle later.
module gf_add
  import gf_vec_add_ctrl_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [GfW-1:0] i_a,
  input  logic [GfW-1:0] i_b,
  output logic [GfW-1:0] o_sum,
  output logic           o_done
);

  logic r_done;

  assign o_sum = i_a ^ i_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= i_start;
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/gf_vec_add_ctrl.sv
// Streams two operand vectors through gf_add and writes the element-wise sum.
// Define GF_VEC_ADD_REG_OUT_EN to register the write port (adds one cycle of latency).
module gf_vec_add_ctrl
  import gf_vec_add_ctrl_pkg::*;
#(
  parameter int unsigned N_ELEM  = DefNElem,
  parameter int unsigned RAM_LAT = DefRamLat,
  parameter int unsigned ADDR_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [GfW-1:0]    i_rd_data_a,
  input  logic [GfW-1:0]    i_rd_data_b,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [GfW-1:0]    o_wr_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0]  LastAddr = ADDR_W'(N_ELEM - 1);
  localparam logic [RAM_LAT-1:0] TopBit   = RAM_LAT'(1) << (RAM_LAT - 1);

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic [RAM_LAT-1:0]  r_vld_sr;
  logic [ADDR_W-1:0]   r_addr_sr [RAM_LAT];
  logic                w_rd_en;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_vld_dly;
  logic [ADDR_W-1:0]   w_addr_dly;
  logic [GfW-1:0]      w_sum;
  logic                w_add_done;
  logic                w_drained;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = StIssue;
          w_cnt_nxt   = '0;
        end
      end
      StIssue: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_cnt;
        if (r_cnt == LastAddr) begin
          w_state_nxt = StDrain;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      StDrain: begin
        if (w_drained) begin
          w_state_nxt = StDone;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_vld_sr <= '0;
      for (int i = 0; i < int'(RAM_LAT); i++) begin
        r_addr_sr[i] <= '0;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_vld_sr <= (r_vld_sr << 1) | RAM_LAT'(w_rd_en);
      for (int i = int'(RAM_LAT) - 1; i > 0; i--) begin
        r_addr_sr[i] <= r_addr_sr[i-1];
      end
      r_addr_sr[0] <= w_rd_addr;
    end
  end

  // Idle read address is forced to 0, so the delayed address is already 0 when not valid.
  assign w_vld_dly  = r_vld_sr[RAM_LAT-1];
  assign w_addr_dly = r_addr_sr[RAM_LAT-1];

  gf_add u_gf_add (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_vld_dly),
    .i_a     (i_rd_data_a),
    .i_b     (i_rd_data_b),
    .o_sum   (w_sum),
    .o_done  (w_add_done)
  );

`ifdef GF_VEC_ADD_REG_OUT_EN
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [GfW-1:0]    r_wr_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= w_vld_dly;
      r_wr_addr <= w_addr_dly;
      r_wr_data <= w_vld_dly ? w_sum : '0;
    end
  end

  // The output register holds the last write, so wait until the whole line is empty.
  assign w_drained = (r_vld_sr == '0);
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
`else
  // Leave DRAIN as the final write leaves the line, so DONE follows it directly.
  assign w_drained = ((r_vld_sr & ~TopBit) == '0);
  assign o_wr_en   = w_vld_dly;
  assign o_wr_addr = w_addr_dly;
  assign o_wr_data = w_vld_dly ? w_sum : '0;
`endif

  assign o_rd_en   = w_rd_en;
  assign o_rd_addr = w_rd_addr;
  assign o_busy    = (r_state != StIdle);
  assign o_done    = (r_state == StDone);

endmodule

// File: tb/tb_gf_vec_add_ctrl.sv
// Scoreboard bench for gf_vec_add_ctrl: three instances (16/1, 5/3, 1/1) against a timing model.
module tb_gf_vec_add_ctrl;

  localparam int NI  = 3;
  localparam int BIG = 1 << 30;
`ifdef GF_VEC_ADD_REG_OUT_EN
  localparam int RO = 1;
`else
  localparam int RO = 0;
`endif

  function automatic int ne(input int k);
    case (k)
      0:       return 16;
      1:       return 5;
      default: return 1;
    endcase
  endfunction

  function automatic int lat(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst   [NI];
  logic       start [NI];
  logic [7:0] rda   [NI];
  logic [7:0] rdb   [NI];
  logic       rd_en [NI];
  logic       wr_en [NI];
  logic       busy  [NI];
  logic       done  [NI];
  logic [7:0] wr_data [NI];
  int         rd_addr_i [NI];
  int         wr_addr_i [NI];

  logic [3:0] ra0, wa0;
  logic [2:0] ra1, wa1;
  logic [0:0] ra2, wa2;
  assign rd_addr_i[0] = int'(ra0);
  assign wr_addr_i[0] = int'(wa0);
  assign rd_addr_i[1] = int'(ra1);
  assign wr_addr_i[1] = int'(wa1);
  assign rd_addr_i[2] = int'(ra2);
  assign wr_addr_i[2] = int'(wa2);

  gf_vec_add_ctrl #(.N_ELEM(16), .RAM_LAT(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]),
    .i_rd_data_a(rda[0]), .i_rd_data_b(rdb[0]),
    .o_rd_en(rd_en[0]), .o_rd_addr(ra0), .o_wr_en(wr_en[0]), .o_wr_addr(wa0),
    .o_wr_data(wr_data[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  gf_vec_add_ctrl #(.N_ELEM(5), .RAM_LAT(3)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]),
    .i_rd_data_a(rda[1]), .i_rd_data_b(rdb[1]),
    .o_rd_en(rd_en[1]), .o_rd_addr(ra1), .o_wr_en(wr_en[1]), .o_wr_addr(wa1),
    .o_wr_data(wr_data[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  gf_vec_add_ctrl #(.N_ELEM(1), .RAM_LAT(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst[2]), .i_start(start[2]),
    .i_rd_data_a(rda[2]), .i_rd_data_b(rdb[2]),
    .o_rd_en(rd_en[2]), .o_rd_addr(ra2), .o_wr_en(wr_en[2]), .o_wr_addr(wa2),
    .o_wr_data(wr_data[2]), .o_busy(busy[2]), .o_done(done[2])
  );

  // Operand memories with per-instance read latency.
  logic [7:0] mem_a [NI][16];
  logic [7:0] mem_b [NI][16];
  int         hist  [NI][4];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      for (int j = 3; j > 0; j--) hist[k][j] <= hist[k][j-1];
      hist[k][0] <= rd_addr_i[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      rda[k] = mem_a[k][hist[k][lat(k)-1]];
      rdb[k] = mem_b[k][hist[k][lat(k)-1]];
    end
  end

  wr_t wq [NI][$];
  int  dq [NI][$];
  int  run_s [NI];
  int  cut   [NI];
  int  errors = 0;
  int  checks = 0;
  bit  mon_on = 1'b0;

  task automatic chk(input string name, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d: got %0h expected %0h", name, k, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < NI; k++) begin
        int  rel;
        int  n;
        int  l;
        bit  alive;
        bit  exp_rd;
        wr_t e;
        int  dc;
        n      = ne(k);
        l      = lat(k);
        rel    = cyc - run_s[k];
        alive  = (cyc <= cut[k]);
        exp_rd = alive && rel >= 1 && rel <= n;
        chk("rd_en", k, (rd_en[k] === 1'b1) ? 1 : 0, int'(exp_rd));
        if (exp_rd) chk("rd_addr", k, rd_addr_i[k], rel - 1);
        chk("busy", k, (busy[k] === 1'b1) ? 1 : 0,
            int'(alive && rel >= 1 && rel <= n + l + 1 + RO));
        if (wr_en[k] !== 1'b0) begin
          if (wq[k].size() == 0) begin
            chk("wr_unexpected", k, (wr_en[k] === 1'b1) ? 1 : 2, 0);
          end else begin
            e = wq[k].pop_front();
            chk("wr_cycle", k, cyc, e.cyc);
            chk("wr_addr", k, wr_addr_i[k], e.addr);
            chk("wr_data", k, int'(wr_data[k]), e.data);
          end
        end
        if (done[k] !== 1'b0) begin
          if (dq[k].size() == 0) begin
            chk("done_unexpected", k, (done[k] === 1'b1) ? 1 : 2, 0);
          end else begin
            dc = dq[k].pop_front();
            chk("done_cycle", k, cyc, dc);
          end
        end
      end
    end
  end

  task automatic fill(input int k, input int mode);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0: begin mem_a[k][i] = 8'(i);  mem_b[k][i] = 8'hFF; end
        1: begin mem_a[k][i] = 8'h5A;  mem_b[k][i] = 8'h5A; end
        2: begin mem_a[k][i] = 8'h53;  mem_b[k][i] = 8'hCA; end
        default: begin mem_a[k][i] = 8'($urandom); mem_b[k][i] = 8'($urandom); end
      endcase
    end
  endtask

  // Called at a negedge; pushes writes/done expected at or before cut_c.
  task automatic issue(input int k, input bit hold, input int cut_c);
    int  s;
    int  n;
    int  l;
    wr_t e;
    s = cyc;
    n = ne(k);
    l = lat(k);
    start[k] = 1'b1;
    run_s[k] = s;
    cut[k]   = cut_c;
    for (int i = 0; i < n; i++) begin
      e.cyc  = s + 1 + l + RO + i;
      e.addr = i;
      e.data = int'(mem_a[k][i] ^ mem_b[k][i]);
      if (e.cyc <= cut_c) wq[k].push_back(e);
    end
    if (s + n + l + 1 + RO <= cut_c) dq[k].push_back(s + n + l + 1 + RO);
    if (!hold) begin
      @(negedge clk);
      start[k] = 1'b0;
    end
  endtask

  task automatic wait_drain(input int k);
    int n;
    n = 0;
    while ((wq[k].size() != 0 || dq[k].size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout inst%0d: got %0d writes %0d dones pending expected 0",
               k, wq[k].size(), dq[k].size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s;
    int d;
    for (int k = 0; k < NI; k++) begin
      rst[k]   = 1'b1;
      start[k] = 1'b0;
      run_s[k] = -1000;
      cut[k]   = BIG;
      fill(k, 3);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_outputs", k,
          int'({rd_en[k], wr_en[k], busy[k], done[k], wr_data[k], rd_addr_i[k][3:0]}), 0);
    end
    mon_on = 1'b1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    @(negedge clk);

    fill(0, 0); issue(0, 1'b0, BIG); wait_drain(0);
    fill(1, 1); issue(1, 1'b0, BIG); wait_drain(1);
    fill(2, 2); issue(2, 1'b0, BIG); wait_drain(2);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NI; k++) fill(k, 3);
      for (int k = 0; k < NI; k++) issue(k, 1'b0, BIG);
      for (int k = 0; k < NI; k++) wait_drain(k);
    end

    // Start held high across a run: the second run is accepted the cycle after done.
    fill(0, 3);
    s = cyc;
    issue(0, 1'b1, BIG);
    d = s + ne(0) + lat(0) + 1 + RO;
    while (cyc != d + 1) @(negedge clk);
    issue(0, 1'b0, BIG);
    wait_drain(0);

    // Reset during cycle 7 of a run.
    fill(0, 3);
    s = cyc;
    issue(0, 1'b0, s + 7);
    while (cyc != s + 7) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (30) @(negedge clk);
    wait_drain(0);
    fill(0, 3);
    issue(0, 1'b0, BIG);
    wait_drain(0);

    for (int k = 0; k < NI; k++) begin
      if (wq[k].size() != 0 || dq[k].size() != 0) begin
        checks++;
        errors++;
        $display("FAIL leftover inst%0d: got %0d pending expected 0",
                 k, wq[k].size() + dq[k].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
